// File: rtl/i2c_share_arb.sv
// rtl/i2c_share_arb.sv - shares one I2C pad pair between the native and APB I2C masters.
// Optional stuck-SCL timeout is compiled in with I2C_SHARE_ARB_TIMEOUT_EN.
module i2c_share_arb #(
  parameter int TBUF_CYC    = 16,
  parameter int TIMEOUT_CYC = 65535,
  parameter bit DEF_SEL     = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       sel_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {S_FREE, S_OWNED, S_ACTIVE, S_HOLD} state_e;

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic [7:0] tbuf_q, tbuf_d;
  logic       scl_m_q, scl_s_q, scl_h_q;
  logic       sda_m_q, sda_s_q, sda_h_q;
  logic       start_det, stop_det, bus_idle, win_native;

  // Synchronizers idle high so reset never fakes a START or STOP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_m_q <= 1'b1; scl_s_q <= 1'b1; scl_h_q <= 1'b1;
      sda_m_q <= 1'b1; sda_s_q <= 1'b1; sda_h_q <= 1'b1;
    end else begin
      scl_m_q <= scl_i; scl_s_q <= scl_m_q; scl_h_q <= scl_s_q;
      sda_m_q <= sda_i; sda_s_q <= sda_m_q; sda_h_q <= sda_s_q;
    end
  end

  assign start_det  = scl_s_q & scl_h_q & sda_h_q & ~sda_s_q;
  assign stop_det   = scl_s_q & scl_h_q & ~sda_h_q & sda_s_q;
  assign bus_idle   = scl_s_q & sda_s_q;
  assign win_native = (req_i == 2'b11) ? ~last_q : req_i[1];

`ifdef I2C_SHARE_ARB_TIMEOUT_EN
  logic [15:0] to_q, to_d;
  logic        to_fire, timeout_q;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    tbuf_d  = '0;
`ifdef I2C_SHARE_ARB_TIMEOUT_EN
    to_d    = '0;
    to_fire = 1'b0;
`endif
    case (state_q)
      S_FREE: begin
        if (start_det) begin
          state_d = S_ACTIVE;
        end else if (|req_i) begin
          state_d = S_OWNED;
          gnt_d   = win_native ? 2'b10 : 2'b01;
          sel_d   = win_native;
          last_d  = win_native;
        end
      end
      S_OWNED: begin
        if (start_det) begin
          state_d = S_ACTIVE;
        end else if ((req_i & gnt_q) == 2'b00) begin
          state_d = S_FREE;
          gnt_d   = 2'b00;
        end
      end
      S_ACTIVE: begin
        if (stop_det) begin
          state_d = S_HOLD;
        end
`ifdef I2C_SHARE_ARB_TIMEOUT_EN
        else if (!scl_s_q) begin
          if (to_q == 16'(TIMEOUT_CYC - 1)) begin
            to_fire = 1'b1;
            gnt_d   = 2'b00;
            state_d = S_FREE;
          end else begin
            to_d = to_q + 16'd1;
          end
        end
`endif
      end
      S_HOLD: begin
        if (start_det) begin
          state_d = S_ACTIVE;
        end else if (bus_idle) begin
          if (tbuf_q == 8'(TBUF_CYC - 1)) begin
            state_d = S_FREE;
            gnt_d   = 2'b00;
          end else begin
            tbuf_d = tbuf_q + 8'd1;
          end
        end else begin
          tbuf_d = tbuf_q;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_FREE;
      gnt_q   <= 2'b00;
      sel_q   <= DEF_SEL;
      last_q  <= DEF_SEL;
      tbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      tbuf_q  <= tbuf_d;
    end
  end

`ifdef I2C_SHARE_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_q      <= to_d;
      timeout_q <= to_fire;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign gnt_o  = gnt_q;
  assign sel_o  = sel_q;
  assign busy_o = (state_q == S_ACTIVE) || (state_q == S_HOLD);

endmodule

// File: tb/tb_i2c_share_arb.sv
// tb/tb_i2c_share_arb.sv - directed self-checking bench for i2c_share_arb.
module tb_i2c_share_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       sel, scl, sda, busy, tmo;
  int         checks = 0;
  int         errors = 0;
  int         pulses;

  i2c_share_arb #(.TBUF_CYC(16), .TIMEOUT_CYC(100), .DEF_SEL(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .sel_o(sel),
    .scl_i(scl), .sda_i(sda), .busy_o(busy), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; scl = 1'b1; sda = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // START with both lines high; leaves SCL low and the FSM in ACTIVE.
  task automatic i2c_start();
    sda = 1'b0; tick(4);
    scl = 1'b0; tick(1);
  endtask

  task automatic i2c_bit(input logic b);
    sda = b;    tick(1);
    scl = 1'b1; tick(2);
    scl = 1'b0; tick(1);
  endtask

  // STOP from SCL low; returns three edges after SDA rises, i.e. HOLD just entered.
  task automatic i2c_stop();
    sda = 1'b0; tick(1);
    scl = 1'b1; tick(3);
    sda = 1'b1; tick(3);
  endtask

  initial begin
    do_reset();
    check("rst_gnt", gnt, 2'b00);
    check("rst_sel", sel, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_tmo", tmo, 1'b0);

    req = 2'b10; tick(1);
    check("nat_gnt", gnt, 2'b10);
    check("nat_sel", sel, 1'b1);
    req = 2'b00; tick(1);
    check("drop_gnt", gnt, 2'b00);
    check("drop_sel", sel, 1'b1);

    // Round robin from reset: APB first, native after release.
    do_reset();
    req = 2'b11; tick(1);
    check("rr_gnt_apb", gnt, 2'b01);
    check("rr_sel_apb", sel, 1'b0);
    i2c_start();
    check("rr_busy", busy, 1'b1);
    i2c_bit(1'b1); i2c_bit(1'b0);
    i2c_stop();
    tick(15);
    check("rr_hold_gnt", gnt, 2'b01);
    tick(1);
    check("rr_rel_gnt", gnt, 2'b00);
    check("rr_rel_busy", busy, 1'b0);
    tick(1);
    check("rr_gnt_nat", gnt, 2'b10);
    check("rr_sel_nat", sel, 1'b1);

    // Owner drops req during transfer: grant kept until STOP + bus-free time.
    i2c_start();
    req = 2'b00;
    i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b1);
    check("drop_act_gnt", gnt, 2'b10);
    check("drop_act_busy", busy, 1'b1);
    i2c_stop();
    tick(15);
    check("drop_hold_busy", busy, 1'b1);
    tick(1);
    check("drop_rel_busy", busy, 1'b0);
    check("drop_rel_gnt", gnt, 2'b00);

    // Repeated START, then a START during HOLD restarts the bus-free count.
    req = 2'b10; tick(1);
    check("rs_gnt", gnt, 2'b10);
    i2c_start();
    i2c_bit(1'b1);
    sda = 1'b1; tick(1);
    scl = 1'b1; tick(2);
    sda = 1'b0; tick(4);
    scl = 1'b0; tick(1);
    check("rs_busy", busy, 1'b1);
    check("rs_gnt_act", gnt, 2'b10);
    req = 2'b00;
    i2c_stop();
    tick(10);
    check("hold10_busy", busy, 1'b1);
    sda = 1'b0; tick(3);
    check("hold_rs_busy", busy, 1'b1);
    check("hold_rs_gnt", gnt, 2'b10);
    scl = 1'b0; tick(1);
    i2c_stop();
    tick(15);
    check("hold2_gnt", gnt, 2'b10);
    tick(1);
    check("hold2_rel", gnt, 2'b00);

    // Stuck SCL in ACTIVE.
    req = 2'b01; tick(1);
    check("to_gnt", gnt, 2'b01);
    check("to_sel", sel, 1'b0);
    i2c_start();
    req = 2'b00;
    pulses = 0;
    for (int i = 0; i < 130; i++) begin
      tick(1);
      if (tmo) pulses++;
    end
`ifdef I2C_SHARE_ARB_TIMEOUT_EN
    check("to_pulses", pulses, 1);
    check("to_gnt_clr", gnt, 2'b00);
    check("to_busy", busy, 1'b0);
`else
    check("to_pulses", pulses, 0);
    check("to_gnt_held", gnt, 2'b01);
    check("to_busy", busy, 1'b1);
`endif
    i2c_stop();
    tick(20);
    check("to_end_gnt", gnt, 2'b00);
    check("to_end_busy", busy, 1'b0);

    // Foreign START in FREE, request arriving mid-transfer.
    i2c_start();
    check("frn_busy", busy, 1'b1);
    check("frn_gnt", gnt, 2'b00);
    req = 2'b10;
    i2c_bit(1'b0); i2c_bit(1'b1);
    check("frn_req_gnt", gnt, 2'b00);
    i2c_stop();
    tick(15);
    check("frn_hold_gnt", gnt, 2'b00);
    check("frn_hold_busy", busy, 1'b1);
    tick(1);
    check("frn_free_gnt", gnt, 2'b00);
    tick(1);
    check("frn_late_gnt", gnt, 2'b10);
    check("frn_late_sel", sel, 1'b1);

    // Asynchronous reset mid-transaction.
    i2c_start();
    #3 rst = 1'b1;
    #1;
    check("arst_gnt", gnt, 2'b00);
    check("arst_busy", busy, 1'b0);
    check("arst_sel", sel, 1'b1);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
